// File: rtl/tcam_srch_upd_sched.sv
// ---------------------------------------------------------------------------
// tcam_srch_upd_sched
//
// Scheduler for one SRAM-based TCAM layer. The N APT tables share a single
// SRAM port. Search keys pass straight through to the layer datapath, and a
// rule update is turned into a column write of bit k over every row of every
// APT table. An update only gets the port on cycles where no search is
// accepted. After MAX_DEFER back-to-back searches have won during an update,
// the next cycle is forced to be a write slot by dropping srch_ready.
//
// Parameters
//   N          number of sub-words / APT tables (must divide W)
//   W          search key width; sub-word width w = W/N, APT depth 2**w
//   K          rules per layer (APT row width)
//   MAX_DEFER  max consecutive search-won cycles during an update (>=1)
//
// Ports
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   srch_valid/ready/key      search key handshake
//   lyr_key_valid, lyr_key    registered key to the layer datapath
//   upd_valid/ready           update request handshake
//   upd_idx/value/mask/del    rule column, value, don't-care mask, delete flag
//   apt_we/addr/bit/wdata     registered APT column-write port
//   upd_done                  one-cycle pulse with the last write of an update
//
// Optional build macro TCAM_SCHED_STATS_EN adds saturating statistics outputs
// stat_srch / stat_upd / stat_force (searches accepted, updates completed,
// forced write slots).
// ---------------------------------------------------------------------------
module tcam_srch_upd_sched #(
    parameter int N         = 2,
    parameter int W         = 32,
    parameter int K         = 256,
    parameter int MAX_DEFER = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 srch_valid,
    output logic                 srch_ready,
    input  logic [W-1:0]         srch_key,
    output logic                 lyr_key_valid,
    output logic [W-1:0]         lyr_key,
    input  logic                 upd_valid,
    output logic                 upd_ready,
    input  logic [$clog2(K)-1:0] upd_idx,
    input  logic [W-1:0]         upd_value,
    input  logic [W-1:0]         upd_mask,
    input  logic                 upd_del,
    output logic [N-1:0]         apt_we,
    output logic [W/N-1:0]       apt_addr,
    output logic [$clog2(K)-1:0] apt_bit,
    output logic                 apt_wdata,
    output logic                 upd_done
`ifdef TCAM_SCHED_STATS_EN
    ,
    output logic [31:0]          stat_srch,
    output logic [31:0]          stat_upd,
    output logic [31:0]          stat_force
`endif
);

    localparam int SW = W / N;
    localparam int IW = $clog2(K);
    localparam int TW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = $clog2(MAX_DEFER + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   t_cnt;
    logic [SW-1:0]   a_cnt;
    logic [DW-1:0]   defer_cnt;

    logic [IW-1:0]   req_idx;
    logic [W-1:0]    req_value;
    logic [W-1:0]    req_mask;
    logic            req_del;

    logic            srch_acc;
    logic            upd_acc;
    logic            slot;
    logic            last_slot;

    // Sub-word t of a key; t=0 is the most significant sub-word.
    function automatic logic [SW-1:0] sub_word(input logic [W-1:0] vec, input logic [TW-1:0] t);
        logic [W-1:0] sh;
        sh = vec >> (SW * (N - 1 - int'(t)));
        return sh[SW-1:0];
    endfunction

    // Bit stored at APT row a for this rule: row matches the sub-word value
    // on every cared-about bit, and deletes always clear.
    function automatic logic match_bit(input logic [SW-1:0] a, input logic [SW-1:0] v,
                                       input logic [SW-1:0] m, input logic del);
        return !del && (((a ^ v) & ~m) == '0);
    endfunction

    assign srch_acc  = srch_valid && srch_ready;
    assign upd_acc   = upd_valid && upd_ready;
    assign slot      = (state == RUN) && !srch_acc;
    assign last_slot = slot && (t_cnt == TW'(N - 1)) && (a_cnt == '1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (upd_acc) state_nxt = RUN;
            RUN:     if (last_slot) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded handshakes; searches are blocked only to force a write
    always_comb begin
        srch_ready = !((state == RUN) && (defer_cnt == DW'(MAX_DEFER)));
        upd_ready  = (state == IDLE);
    end

    // Request capture; held for the whole update
    always_ff @(posedge clk) begin
        if (upd_acc) begin
            req_idx   <= upd_idx;
            req_value <= upd_value;
            req_mask  <= upd_mask;
            req_del   <= upd_del;
        end
    end

    // ---- slot decision -> registered outputs (one cycle later) ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_cnt         <= '0;
            a_cnt         <= '0;
            defer_cnt     <= '0;
            lyr_key_valid <= 1'b0;
            lyr_key       <= '0;
            apt_we        <= '0;
            apt_addr      <= '0;
            apt_bit       <= '0;
            apt_wdata     <= 1'b0;
            upd_done      <= 1'b0;
        end else begin
            lyr_key_valid <= srch_acc;
            if (srch_acc) lyr_key <= srch_key;

            // Consecutive search wins inside an update; any write slot clears it
            defer_cnt <= (state == RUN && srch_acc) ? defer_cnt + DW'(1) : '0;

            if (state == IDLE) begin
                t_cnt <= '0;
                a_cnt <= '0;
            end else if (slot) begin
                a_cnt <= a_cnt + SW'(1);
                if (a_cnt == '1) t_cnt <= t_cnt + TW'(1);
            end

            apt_we   <= slot ? (N'(1) << t_cnt) : '0;
            upd_done <= last_slot;
            if (slot) begin
                apt_addr  <= a_cnt;
                apt_bit   <= req_idx;
                apt_wdata <= match_bit(a_cnt, sub_word(req_value, t_cnt),
                                       sub_word(req_mask, t_cnt), req_del);
            end
        end
    end

`ifdef TCAM_SCHED_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != '1) ? v + 32'd1 : v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_srch  <= '0;
            stat_upd   <= '0;
            stat_force <= '0;
        end else begin
            stat_srch  <= sat_inc(stat_srch, srch_acc);
            stat_upd   <= sat_inc(stat_upd, last_slot);
            stat_force <= sat_inc(stat_force, slot && (defer_cnt == DW'(MAX_DEFER)));
        end
    end
`endif

endmodule
